// File: rtl/uart_cmd_parser_pkg.sv
// Shared frame constants, FSM state codes and the frame checksum for the UART command parser.
package uart_cmd_parser_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_CMD  = 3'd1;
    localparam logic [2:0] ST_GET_ADDR = 3'd2;
    localparam logic [2:0] ST_GET_DATA = 3'd3;
    localparam logic [2:0] ST_GET_CSUM = 3'd4;
    localparam logic [2:0] ST_ISSUE    = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CMD_WR_DEF    = 8'h57;
    localparam logic [7:0] CMD_RD_DEF    = 8'h52;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    // 8-bit wrapping sum over CMD, ADDR and DATA.
    function automatic logic [7:0] frame_csum(input logic [7:0] c, input logic [7:0] a,
                                              input logic [7:0] d);
        logic [7:0] s;
        s = c + a + d;
        return s;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Receive-FIFO pop side plus the command valid/ready side of the parser.
interface uart_cmd_parser_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;

    modport master (
        input  rx_empty, r_data, cmd_ready,
        output rd_uart, cmd_valid, cmd_write, cmd_addr, cmd_wdata
    );

    modport slave (
        output rx_empty, r_data, cmd_ready,
        input  rd_uart, cmd_valid, cmd_write, cmd_addr, cmd_wdata
    );
endinterface

// File: rtl/uart_cmd_parser_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles, pulses expire combinationally on the last one.
// Latency: expire asserted in the LIMIT-th consecutive enabled cycle; no backpressure.
// Counter clears on clr or on expiry.
module uart_idle_timer #(
    parameter int LIMIT = 100000,
    parameter int TO_W  = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [TO_W-1:0] cnt;

    assign expire = en & ~clr & (cnt == TO_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ADDR/DATA/CSUM frames from the UART RX FIFO into register commands.
// Latency: cmd_valid visible the cycle after the CSUM byte is popped.
// Backpressure: while a command waits on cmd_ready no bytes are popped; the FIFO absorbs it.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         TO_W        = 17
) (
    input  logic             clk,
    input  logic             reset,
    uart_cmd_parser_if.master bus,
    output logic [7:0]       csum_err_cnt,
    output logic [7:0]       bad_cmd_cnt,
    output logic [7:0]       timeout_cnt
);
    logic [2:0] state;
    logic [7:0] cmd_q, addr_q, data_q;
    cmd_t       cmd_out;
    logic       cmd_valid_q;
    logic       consume, in_get, expire;

    assign consume = ~bus.rx_empty & (state != ST_ISSUE);
    assign in_get  = state inside {ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CSUM};

    assign bus.rd_uart   = consume;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_out.write;
    assign bus.cmd_addr  = cmd_out.addr;
    assign bus.cmd_wdata = cmd_out.wdata;

    uart_idle_timer #(.LIMIT(TIMEOUT_CYC), .TO_W(TO_W)) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (consume | ~in_get),
        .en     (in_get & bus.rx_empty),
        .expire (expire)
    );

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            cmd_out      <= '0;
            cmd_valid_q  <= 1'b0;
            csum_err_cnt <= '0;
            bad_cmd_cnt  <= '0;
            timeout_cnt  <= '0;
        end else if (expire) begin
            state       <= ST_IDLE;
            timeout_cnt <= sat_inc(timeout_cnt);
        end else if (consume) begin
            case (state)
                ST_IDLE:     if (bus.r_data == SYNC_BYTE) state <= ST_GET_CMD;
                ST_GET_CMD:  begin cmd_q  <= bus.r_data; state <= ST_GET_ADDR; end
                ST_GET_ADDR: begin addr_q <= bus.r_data; state <= ST_GET_DATA; end
                ST_GET_DATA: begin data_q <= bus.r_data; state <= ST_GET_CSUM; end
                ST_GET_CSUM: begin
                    if (frame_csum(cmd_q, addr_q, data_q) != bus.r_data) begin
                        csum_err_cnt <= sat_inc(csum_err_cnt);
                        state        <= ST_IDLE;
                    end else if (cmd_q == CMD_WR || cmd_q == CMD_RD) begin
                        cmd_out.write <= (cmd_q == CMD_WR);
                        cmd_out.addr  <= addr_q;
                        cmd_out.wdata <= (cmd_q == CMD_WR) ? data_q : 8'h00;
                        cmd_valid_q   <= 1'b1;
                        state         <= ST_ISSUE;
                    end else begin
                        bad_cmd_cnt <= sat_inc(bad_cmd_cnt);
                        state       <= ST_IDLE;
                    end
                end
                default:     state <= ST_IDLE;
            endcase
        end else if (state == ST_ISSUE && bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state       <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frame table, corner sequences, random frames vs a frame-level model.
module tb_uart_cmd_parser;
    import uart_cmd_parser_pkg::*;

    localparam int TO_CYC = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] csum_err_cnt, bad_cmd_cnt, timeout_cnt;

    always #5 clk = ~clk;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(.TIMEOUT_CYC(TO_CYC), .TO_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .csum_err_cnt (csum_err_cnt),
        .bad_cmd_cnt  (bad_cmd_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    typedef struct {
        logic [63:0] bytes;   // first byte in [63:56]
        int          len;
        bit          has_cmd;
        bit          w;
        logic [7:0]  a;
        logic [7:0]  d;
        int          d_csum;
        int          d_bad;
    } vec_t;

    logic [7:0] fifo[$];
    cmd_t       got_q[$];
    cmd_t       exp_q[$];
    cmd_t       hold;
    bit         hold_v, seen_vld, rand_rdy;
    int         n_chk, n_pass;
    int         pop_cnt, rd_err, issue_pop_err, stab_err;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic drive();
        bus.rx_empty = (fifo.size() == 0);
        bus.r_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive();
    endtask

    // One clock: observe at negedge, update FIFO model after the edge.
    task automatic cycle();
        logic       popped;
        logic [7:0] tmp;
        cmd_t       cur;
        @(negedge clk);
        popped   = bus.rd_uart;
        seen_vld = bus.cmd_valid;
        cur      = '{bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        if (popped) pop_cnt++;
        if (popped && fifo.size() == 0) rd_err++;
        if (bus.cmd_valid && bus.rd_uart) issue_pop_err++;
        if (bus.cmd_valid && bus.cmd_ready) got_q.push_back(cur);
        if (bus.cmd_valid && !bus.cmd_ready) begin
            if (hold_v && hold != cur) stab_err++;
            hold_v = 1'b1;
            hold   = cur;
        end else begin
            hold_v = 1'b0;
        end
        @(posedge clk);
        #1;
        if (popped && fifo.size() > 0) tmp = fifo.pop_front();
        if (rand_rdy) bus.cmd_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic drain(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (fifo.size() == 0 && !bus.cmd_valid) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done) check({name, "_drain"}, 0, 1);
    endtask

    task automatic do_reset();
        fifo.delete();
        drive();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] s);
        push(SYNC_BYTE_DEF); push(c); push(a); push(d); push(s);
    endtask

    vec_t tbl[7];

    initial begin
        int          c0, b0, k;
        logic [7:0]  s[$];
        logic [7:0]  f[4];
        logic [7:0]  sum, op;
        int          st, e_csum, e_bad, kind;

        tbl[0] = '{64'hA5_57_10_3C_A3_00_00_00, 5, 1, 1, 8'h10, 8'h3C, 0, 0};
        tbl[1] = '{64'h00_FF_3C_A5_52_20_00_72, 8, 1, 0, 8'h20, 8'h00, 0, 0};
        tbl[2] = '{64'hA5_57_10_3C_00_00_00_00, 5, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[3] = '{64'hA5_52_20_55_C7_00_00_00, 5, 1, 0, 8'h20, 8'h00, 0, 0};
        tbl[4] = '{64'hA5_A5_01_02_A8_00_00_00, 5, 0, 0, 8'h00, 8'h00, 0, 1};
        tbl[5] = '{64'hA5_57_F0_20_67_00_00_00, 5, 1, 1, 8'hF0, 8'h20, 0, 0};
        tbl[6] = '{64'hA5_57_A5_A5_A1_00_00_00, 5, 1, 1, 8'hA5, 8'hA5, 0, 0};

        n_chk = 0; n_pass = 0; pop_cnt = 0; rd_err = 0; issue_pop_err = 0; stab_err = 0;
        hold_v = 0; rand_rdy = 0;
        bus.cmd_ready = 1'b0;
        drive();
        do_reset();

        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_write", bus.cmd_write, 0);
        check("rst_cmd_addr",  bus.cmd_addr, 0);
        check("rst_cmd_wdata", bus.cmd_wdata, 0);
        check("rst_csum_cnt",  csum_err_cnt, 0);
        check("rst_bad_cnt",   bad_cmd_cnt, 0);
        check("rst_to_cnt",    timeout_cnt, 0);
        check("rst_rd_uart",   bus.rd_uart, 0);

        // Directed frame table
        bus.cmd_ready = 1'b1;
        foreach (tbl[i]) begin
            c0 = csum_err_cnt; b0 = bad_cmd_cnt; pop_cnt = 0;
            got_q.delete();
            for (int j = 0; j < tbl[i].len; j++) push(tbl[i].bytes[63 - 8*j -: 8]);
            drain($sformatf("tbl%0d", i), 100);
            check($sformatf("tbl%0d_pops", i), pop_cnt, tbl[i].len);
            check($sformatf("tbl%0d_ncmd", i), got_q.size(), int'(tbl[i].has_cmd));
            if (tbl[i].has_cmd && got_q.size() > 0) begin
                check($sformatf("tbl%0d_write", i), got_q[0].write, tbl[i].w);
                check($sformatf("tbl%0d_addr", i),  got_q[0].addr, tbl[i].a);
                check($sformatf("tbl%0d_wdata", i), got_q[0].wdata, tbl[i].d);
            end
            check($sformatf("tbl%0d_csum_delta", i), csum_err_cnt - c0, tbl[i].d_csum);
            check($sformatf("tbl%0d_bad_delta", i), bad_cmd_cnt - b0, tbl[i].d_bad);
            check($sformatf("tbl%0d_to", i), timeout_cnt, 0);
        end

        // Backpressure: two frames queued, consumer stalled
        got_q.delete(); pop_cnt = 0; stab_err = 0; issue_pop_err = 0;
        bus.cmd_ready = 1'b0;
        push_frame(8'h57, 8'h10, 8'h3C, 8'hA3);
        push_frame(8'h52, 8'h20, 8'h00, 8'h72);
        for (int i = 0; i < 60; i++) cycle();
        check("bp_pops", pop_cnt, 5);
        check("bp_valid_held", bus.cmd_valid, 1);
        check("bp_addr_held", bus.cmd_addr, 8'h10);
        check("bp_stable", stab_err, 0);
        check("bp_no_issue_pop", issue_pop_err, 0);
        bus.cmd_ready = 1'b1;
        cycle();
        check("bp_first_hs", got_q.size(), 1);
        k = 0; seen_vld = 0;
        while (!seen_vld && k < 20) begin
            cycle();
            k++;
        end
        check("bp_second_latency", k, 6);
        check("bp_ncmd", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("bp_second_write", got_q[1].write, 0);
            check("bp_second_addr", got_q[1].addr, 8'h20);
        end
        drain("bp", 50);

        // Timeout after SYNC+CMD, then recovery
        got_q.delete();
        push(8'hA5); push(8'h57);
        cycle(); cycle();
        for (int i = 0; i < TO_CYC - 1; i++) cycle();
        check("to_not_yet", timeout_cnt, 0);
        cycle();
        check("to_fired", timeout_cnt, 1);
        push_frame(8'h57, 8'h33, 8'h44, 8'hCE);
        drain("to_recover", 50);
        check("to_recover_ncmd", got_q.size(), 1);
        if (got_q.size() == 1) check("to_recover_addr", got_q[0].addr, 8'h33);

        // Byte arriving in the expiry cycle wins
        got_q.delete();
        push(8'hA5); push(8'h57);
        cycle(); cycle();
        for (int i = 0; i < TO_CYC - 1; i++) cycle();
        push(8'h10); push(8'h3C); push(8'hA3);
        drain("to_edge", 50);
        check("to_edge_cnt", timeout_cnt, 1);
        check("to_edge_ncmd", got_q.size(), 1);
        if (got_q.size() == 1) check("to_edge_wdata", got_q[0].wdata, 8'h3C);

        // Bad opcode saturation
        for (int i = 0; i < 300; i++) push_frame(8'h41, 8'h00, 8'h00, 8'h41);
        drain("sat", 4000);
        check("sat_bad_cnt", bad_cmd_cnt, 255);

        // Reset mid-frame
        got_q.delete();
        push(8'hA5); push(8'h57);
        cycle(); cycle();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        check("rmf_bad_cnt", bad_cmd_cnt, 0);
        check("rmf_csum_cnt", csum_err_cnt, 0);
        check("rmf_to_cnt", timeout_cnt, 0);
        push(8'h10); push(8'h3C); push(8'hA3);
        drain("rmf_hunt", 50);
        check("rmf_hunt_ncmd", got_q.size(), 0);
        check("rmf_hunt_csum", csum_err_cnt, 0);
        push_frame(8'h52, 8'h77, 8'h01, 8'hCA);
        drain("rmf_frame", 50);
        check("rmf_frame_ncmd", got_q.size(), 1);
        if (got_q.size() == 1) check("rmf_frame_addr", got_q[0].addr, 8'h77);

        // Random frames vs frame-level model
        do_reset();
        s.delete();
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            f[0] = (kind == 3) ? 8'h41 + 8'($urandom_range(0, 3)) * 8'h20 : ($urandom_range(0, 1) ? 8'h57 : 8'h52);
            f[1] = 8'($urandom);
            f[2] = 8'($urandom);
            f[3] = f[0] + f[1] + f[2];
            if (kind == 2) f[3] = f[3] ^ 8'($urandom_range(1, 255));
            if (kind == 4) begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'hA5) op = 8'h00;
                s.push_back(op);
            end else begin
                s.push_back(8'hA5);
                for (int j = 0; j < 4; j++) s.push_back(f[j]);
            end
        end
        exp_q.delete(); e_csum = 0; e_bad = 0; st = 0;
        foreach (s[i]) begin
            if (st == 0) begin
                if (s[i] == 8'hA5) st = 1;
            end else begin
                f[st-1] = s[i];
                st++;
                if (st == 5) begin
                    st = 0;
                    sum = f[0] + f[1] + f[2];
                    if (sum != f[3]) e_csum++;
                    else if (f[0] == 8'h57) exp_q.push_back('{1'b1, f[1], f[2]});
                    else if (f[0] == 8'h52) exp_q.push_back('{1'b0, f[1], 8'h00});
                    else e_bad++;
                end
            end
        end
        rd_err = 0; issue_pop_err = 0; stab_err = 0;
        rand_rdy = 1'b1;
        foreach (s[i]) push(s[i]);
        drain("rnd", 5000);
        rand_rdy = 1'b0;
        check("rnd_ncmd", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rnd_cmd%0d", i), int'(got_q[i]), int'(exp_q[i]));
        check("rnd_csum_cnt", csum_err_cnt, (e_csum > 255) ? 255 : e_csum);
        check("rnd_bad_cnt", bad_cmd_cnt, (e_bad > 255) ? 255 : e_bad);
        check("rnd_to_cnt", timeout_cnt, 0);
        check("rnd_stable", stab_err, 0);
        check("rnd_no_issue_pop", issue_pop_err, 0);
        check("rnd_no_empty_pop", rd_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes bytes from the UART receive FIFO and assembles fixed 5-byte command frames: SYNC, CMD, ADDR, DATA, CSUM.
- Issues validated register write/read commands over a valid/ready interface to the control-register block.
- Sits directly downstream of the UART receiver and drives its FIFO pop strobe.
- Counts checksum errors, unknown commands and inter-byte timeouts.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- CMD_WR, 8'h57: write opcode ('W').
- CMD_RD, 8'h52: read opcode ('R').
- TIMEOUT_CYC, 100000: idle clocks mid-frame before abort (about 4 byte times at 19200 baud, 50 MHz).
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- rx_empty, input, 1: receive FIFO empty.
- r_data, input, 8: FIFO head byte, valid whenever rx_empty=0.
- rd_uart, output, 1: FIFO pop, combinational, one byte per cycle.
- cmd_valid, output, 1: command pending.
- cmd_ready, input, 1: consumer accepts.
- cmd_write, output, 1: 1=write, 0=read.
- cmd_addr, output, 8: register address.
- cmd_wdata, output, 8: write data (0 for reads).
- csum_err_cnt, output, 8: saturating checksum-error count.
- bad_cmd_cnt, output, 8: saturating unknown-opcode count.
- timeout_cnt, output, 8: saturating timeout count.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset state: FSM in IDLE; every registered output is 0.
- Reset mid-frame: the partial frame is discarded and all counters clear.
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CSUM, ISSUE.
- Byte consume: rd_uart = ~rx_empty & (state != ISSUE). A byte is consumed in any cycle rd_uart=1, using r_data of that cycle.
- IDLE:
  - Consumed byte == SYNC_BYTE -> GET_CMD.
  - Any other byte is discarded silently, not counted.
- GET_CMD / GET_ADDR / GET_DATA: the consumed byte is latched into cmd/addr/data holding regs and the FSM advances.
- SYNC_BYTE appearing inside a frame is ordinary payload; there is no resync.
- Checksum: csum = (cmd + addr + data) mod 256, an 8-bit wrapping sum.
- GET_CSUM, on consume:
  - Mismatch -> csum_err_cnt++, go to IDLE.
  - Match, opcode is CMD_WR or CMD_RD -> ISSUE. cmd_write, cmd_addr and cmd_wdata are loaded, with cmd_wdata forced to 0 for reads.
  - Match, other opcode -> bad_cmd_cnt++, go to IDLE.
- Latency: cmd_valid rises on the clock edge that consumes the CSUM byte, so it is visible the cycle after.
- ISSUE handshake:
  - cmd_valid=1 and the fields are held stable until cmd_ready=1.
  - On a cycle with cmd_valid & cmd_ready: next cycle cmd_valid=0 and state=IDLE.
  - No FIFO pops during ISSUE, so the FIFO absorbs backpressure.
  - cmd_ready is ignored when cmd_valid=0.
- Timeout counter:
  - Cleared on every consumed byte and held at 0 in IDLE and ISSUE.
  - Increments each cycle in GET_* states with no byte available.
  - On reaching TIMEOUT_CYC-1 with no byte: go to IDLE, timeout_cnt++, counter cleared.
- Simultaneous events:
  - Byte available in the expiry cycle: the byte wins (consumed, no timeout).
  - Error increment at 255: the counter stays at 255.
- Arithmetic widths: counters saturate and never wrap; the checksum wraps.

Decomposition:
- Shared header uart_cmd_defs.vh holds:
  - state encodings (3-bit localparams),
  - SYNC_BYTE, CMD_WR and CMD_RD defaults,
  - a checksum function returning the 8-bit sum.
- One natural sub-module, uart_idle_timer: the TO_W-bit counter with clear/enable inputs and a one-cycle expire pulse.
- Everything else stays inline in the parser FSM.

Test Plan:
- Write frame: FIFO fed A5 57 10 3C A3, cmd_ready=1 -> one cmd_valid pulse with cmd_write=1, cmd_addr=10, cmd_wdata=3C; all counters remain 0.
- Junk then read frame: FIFO fed 00 FF 3C, then A5 52 20 00 72 -> the three junk bytes are popped with no effect; then cmd_write=0, cmd_addr=20, cmd_wdata=00; counters remain 0.
- Bad checksum: A5 57 10 3C 00 -> no cmd_valid, csum_err_cnt=1; a following valid frame decodes normally.
- Backpressure: two valid frames queued, cmd_ready=0 for 50 cycles -> rd_uart=0 throughout ISSUE and fields stable; on cmd_ready=1 the first command transfers, and the second issues 6 cycles after the first handshake cycle (5 pops, then cmd_valid visible).
- Timeout (TIMEOUT_CYC=64): A5 57 then no bytes for 64 cycles -> timeout_cnt=1, FSM in IDLE; the next full frame decodes correctly.
- Bad opcode plus saturation: A5 41 00 00 41 -> bad_cmd_cnt=1; 300 such frames -> bad_cmd_cnt=255.
- Reset mid-frame: reset asserted after A5 57 -> bad_cmd_cnt and all other counters clear; the following CSUM-less bytes are treated as hunting for sync.
